// File: rtl/ecc_mod_sub_pkg.sv
// rtl/ecc_mod_sub_pkg.sv - shared ECC package: FSM state encoding and digit-count helpers
//
// Purpose : common definitions for the digit-serial modular subtractor.
// Contents: state_e enum, ST_* state constants, ndig_of() and idx_width().

package ecc_mod_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        CORR = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_SUB  = SUB;
    localparam logic [1:0] ST_CORR = CORR;
    localparam logic [1:0] ST_DONE = DONE;

    // Number of DW-bit digits in an NBITS-wide operand.
    function automatic int ndig_of(input int nbits, input int dw);
        return nbits / dw;
    endfunction

    // Digit index counter width; kept at least 1 so NDIG=1 still has a counter.
    function automatic int idx_width(input int ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/ecc_mod_sub_if.sv
// rtl/ecc_mod_sub_if.sv - request/response bundle of the modular subtractor
//
// Purpose : groups the operand, control and result signals of ecc_mod_sub.
// Signals : start, a, b, p (requester -> subtractor)
//           busy, done, result (subtractor -> requester)
// Modports: master = requester side, slave = subtractor side.

interface ecc_mod_sub_if #(
    parameter int NBITS = 256
);
    logic             start;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic [NBITS-1:0] p;
    logic             busy;
    logic             done;
    logic [NBITS-1:0] result;

    modport master (
        output start, a, b, p,
        input  busy, done, result
    );

    modport slave (
        input  start, a, b, p,
        output busy, done, result
    );
endinterface

// File: rtl/ecc_digit_addsub.sv
// rtl/ecc_digit_addsub.sv - combinational DW-bit add/subtract with carry/borrow in and out
//
// Purpose: one digit of the rippled add/subtract shared by the SUB and CORR passes.
// Ports  : mode  in  1   0 = x + y + cin, 1 = x - y - cin (cin acts as borrow-in)
//          x, y  in  DW  digit operands
//          cin   in  1   carry-in or borrow-in
//          sum   out DW  digit result
//          cout  out 1   carry-out or borrow-out

module ecc_digit_addsub #(
    parameter int DW = 32
) (
    input  logic          mode,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  logic          cin,
    output logic [DW-1:0] sum,
    output logic          cout
);

    logic [DW:0] wide;

    // DW+1-bit arithmetic: the extra MSB is the carry out on add, and on
    // subtract it is set exactly when x < y + cin (borrow out).
    always_comb begin
        wide = '0;
        if (mode) begin
            wide = {1'b0, x} - {1'b0, y} - {{DW{1'b0}}, cin};
        end else begin
            wide = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, cin};
        end
    end

    assign sum  = wide[DW-1:0];
    assign cout = wide[DW];

endmodule

// File: rtl/ecc_mod_sub.sv
// rtl/ecc_mod_sub.sv - digit-serial modular subtractor r = (a - b) mod p
//
// Purpose: subtracts one DW-bit digit per cycle, LSB digit first, with a rippled
//          borrow; if the full difference underflows a second pass adds p back.
// Ports  : clk         in  rising-edge clock
//          rst         in  asynchronous active-high reset
//          bus (slave) start/a/b/p in, busy/done/result out (see ecc_mod_sub_if)

module ecc_mod_sub
    import ecc_mod_sub_pkg::*;
#(
    parameter int NBITS = 256,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    ecc_mod_sub_if.slave  bus
);

    localparam int             NDIG     = ndig_of(NBITS, DW);
    localparam int             IW       = idx_width(NDIG);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NDIG - 1);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic             bc_q,    bc_d;     // borrow during SUB, carry during CORR
    logic [NBITS-1:0] a_q,     a_d;
    logic [NBITS-1:0] b_q,     b_d;
    logic [NBITS-1:0] p_q,     p_d;
    logic [NBITS-1:0] res_q,   res_d;

    logic             mode;
    logic [DW-1:0]    op_x;
    logic [DW-1:0]    op_y;
    logic [DW-1:0]    dig_sum;
    logic             dig_cout;
    logic             wr_en;
    logic             last_dig;

    assign last_dig = (idx_q == LAST_IDX);

    // SUB works on a_i - b_i; CORR re-reads the stored difference digit and adds p_i.
    always_comb begin
        mode = 1'b1;
        op_x = '0;
        op_y = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) begin
                if (state_q == ST_CORR) begin
                    op_x = res_q[i*DW +: DW];
                    op_y = p_q[i*DW +: DW];
                end else begin
                    op_x = a_q[i*DW +: DW];
                    op_y = b_q[i*DW +: DW];
                end
            end
        end
        if (state_q == ST_CORR) begin
            mode = 1'b0;
        end
    end

    ecc_digit_addsub #(
        .DW (DW)
    ) u_digit (
        .mode (mode),
        .x    (op_x),
        .y    (op_y),
        .cin  (bc_q),
        .sum  (dig_sum),
        .cout (dig_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bc_d    = bc_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        res_d   = res_q;
        wr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    p_d     = bus.p;
                    bc_d    = 1'b0;
                    idx_d   = '0;
                    state_d = ST_SUB;
                end
            end
            ST_SUB: begin
                wr_en = 1'b1;
                bc_d  = dig_cout;
                if (last_dig) begin
                    idx_d = '0;
                    if (dig_cout) begin
                        // a < b: the stored difference is a - b + 2^NBITS, add p back.
                        bc_d    = 1'b0;
                        state_d = ST_CORR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_CORR: begin
                wr_en = 1'b1;
                bc_d  = dig_cout;
                if (last_dig) begin
                    // The top carry cancels the 2^NBITS wrap of the SUB pass.
                    bc_d    = 1'b0;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        for (int i = 0; i < NDIG; i++) begin
            if (wr_en && (idx_q == IW'(i))) begin
                res_d[i*DW +: DW] = dig_sum;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bc_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bc_q    <= bc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            res_q   <= res_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = (state_q == ST_DONE);
    assign bus.result = res_q;

endmodule

// File: tb/tb_ecc_mod_sub.sv
// tb/tb_ecc_mod_sub.sv - directed and reference-model bench for ecc_mod_sub

module tb_ecc_mod_sub;

    localparam logic [255:0] P256 =
        256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ecc_mod_sub_if #(.NBITS(8))   bus8   ();
    ecc_mod_sub_if #(.NBITS(256)) bus256 ();

    ecc_mod_sub #(.NBITS(8), .DW(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    ecc_mod_sub #(.NBITS(256), .DW(32)) dut256 (
        .clk (clk),
        .rst (rst),
        .bus (bus256)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation; mid is the result register seen in the first CORR
    // cycle (only meaningful when a correction pass occurs).
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_r,
                        input int exp_lat, input string tag, output logic [7:0] mid);
        int lat;
        mid        = '0;
        bus8.a     = a;
        bus8.b     = b;
        bus8.start = 1'b1;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        lat = 1;
        while (!bus8.done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 3) mid = bus8.result;
        end
        check_val({tag, " done"}, 256'(bus8.done), 256'(1));
        check_val({tag, " busy"}, 256'(bus8.busy), 256'(1));
        check_val({tag, " lat"}, 256'(lat), 256'(exp_lat));
        check_val({tag, " result"}, 256'(bus8.result), 256'(exp_r));
        @(posedge clk);
        #1;
        check_val({tag, " held"}, 256'(bus8.result), 256'(exp_r));
        check_val({tag, " idle"}, 256'({bus8.busy, bus8.done}), 256'(0));
    endtask

    task automatic run256(input logic [255:0] a, input logic [255:0] b, input string tag);
        int           lat;
        logic [255:0] exp_r;
        int           exp_lat;
        exp_r   = (a >= b) ? (a - b) : (a - b + P256);
        exp_lat = (a >= b) ? 9 : 17;
        bus256.a     = a;
        bus256.b     = b;
        bus256.start = 1'b1;
        @(posedge clk);
        #1 bus256.start = 1'b0;
        lat = 1;
        while (!bus256.done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, " done"}, 256'(bus256.done), 256'(1));
        check_val({tag, " lat"}, 256'(lat), 256'(exp_lat));
        check_val({tag, " result"}, bus256.result, exp_r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]   mid;
        logic [255:0] ra;
        logic [255:0] rb;
        int           lat;
        int           seen;

        bus8.start   = 1'b0;
        bus8.a       = '0;
        bus8.b       = '0;
        bus8.p       = 8'd251;
        bus256.start = 1'b0;
        bus256.a     = '0;
        bus256.b     = '0;
        bus256.p     = P256;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst busy8", 256'(bus8.busy), 256'(0));
        check_val("rst done8", 256'(bus8.done), 256'(0));
        check_val("rst result8", 256'(bus8.result), 256'(0));
        check_val("rst result256", bus256.result, 256'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        run8(8'd200, 8'd50,  8'd150, 3, "200-50",  mid);
        run8(8'd50,  8'd200, 8'd101, 5, "50-200",  mid);
        check_val("50-200 raw", 256'(mid), 256'(8'h6A));
        run8(8'd123, 8'd123, 8'd0,   3, "123-123", mid);
        run8(8'd0,   8'd250, 8'd1,   5, "0-250",   mid);
        check_val("0-250 raw", 256'(mid), 256'(8'd6));
        run8(8'd250, 8'd0,   8'd250, 3, "250-0",   mid);

        // start held high and operands changed during SUB must be ignored
        bus8.a     = 8'd200;
        bus8.b     = 8'd50;
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.a = 8'd50;
        bus8.b = 8'd200;
        lat = 1;
        while (!bus8.done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("ign lat", 256'(lat), 256'(3));
        check_val("ign result", 256'(bus8.result), 256'(150));
        @(posedge clk);
        #1;
        check_val("ign idle", 256'(bus8.busy), 256'(0));
        @(posedge clk);
        #1 bus8.start = 1'b0;
        lat = 1;
        while (!bus8.done && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("next lat", 256'(lat), 256'(5));
        check_val("next result", 256'(bus8.result), 256'(101));
        @(posedge clk);
        #1;

        // reset in the second SUB cycle aborts the operation
        bus8.a     = 8'd50;
        bus8.b     = 8'd200;
        bus8.start = 1'b1;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort busy", 256'(bus8.busy), 256'(0));
        check_val("abort result", 256'(bus8.result), 256'(0));
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus8.done) seen = 1;
        end
        check_val("abort no done", 256'(seen), 256'(0));
        check_val("abort idle result", 256'(bus8.result), 256'(0));
        run8(8'd10, 8'd20, 8'd241, 5, "10-20", mid);

        // 256-bit P-256 regression
        run256(256'd0, 256'd1, "p256 0-1");
        run256(P256 - 256'd1, 256'd0, "p256 pm1-0");
        run256(P256 - 256'd5, P256 - 256'd5, "p256 eq");
        for (int k = 0; k < 6; k++) begin
            ra = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            rb = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            if (ra >= P256) ra = ra - P256;
            if (rb >= P256) rb = rb - P256;
            run256(ra, rb, $sformatf("p256 rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ecc_mod_sub.md
# ecc_mod_sub

Digit-serial modular subtractor for the ECC core. It computes r = (a − b) mod p for field elements a, b < p, working one DW-bit digit per cycle with a rippled borrow between digits. If the raw difference underflows, a second pass adds p back. It sits beside the core's adder datapath as the subtraction unit used by the point-arithmetic sequencer.

## Interface
- NBITS, 256, operand/modulus width; must be a multiple of DW
- DW, 32, digit width processed per cycle
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  NBITS  minuend, < p
- b  in  NBITS  subtrahend, < p
- p  in  NBITS  modulus, odd, > 1
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse; result valid
- result  out  NBITS  (a − b) mod p; held from done until the next accepted start

## Operation
- NDIG = NBITS/DW. Digit i covers bits [i*DW +: DW]. Processing order is LSB digit first.
- States:
  - IDLE: start=1 latches a, b, p into internal registers, clears borrow/carry, sets digit index to 0, and moves to SUB.
  - SUB: d_i = a_i − b_i − borrow; the new borrow is registered and d_i is written into result digit i. After digit NDIG−1: if the final borrow is 1, go to CORR with carry=0 and index=0; otherwise go to DONE.
  - CORR: r_i = d_i + p_i + carry, written back into result digit i. The final carry is discarded. After digit NDIG−1, go to DONE.
  - DONE: done=1 for one cycle, then return to IDLE.
- Arithmetic: each digit operation is DW+1 bits wide; the MSB is the borrow or carry out.
- Illegal operands (a ≥ p or b ≥ p): the result is the NBITS-bit truncated value of the same algorithm. No error flag is raised.
- start is ignored in SUB, CORR and DONE. Operands are read only in the cycle start is accepted, so inputs may change afterwards.
- Reset values: state=IDLE, busy=0, done=0, result=0, and all internal registers 0.
- rst asserted mid-operation aborts the operation immediately. No done pulse is produced, and after deassertion the block idles with result=0.

## Timing
- start is accepted at edge T. SUB occupies cycles T+1 … T+NDIG.
- No underflow: done=1 in cycle T+NDIG+1. Latency is NDIG+1.
- Underflow: CORR occupies T+NDIG+1 … T+2·NDIG, and done=1 in T+2·NDIG+1. Latency is 2·NDIG+1.
- Earliest next accepted start is the cycle after done, because done occurs in the DONE state and start is sampled in IDLE. There is no back-to-back overlap.
- busy=1 exactly in the SUB, CORR and DONE cycles.
- result changes only on the edges where SUB or CORR writes a digit. Intermediate values are visible but must not be used before done.
- Single-digit configuration (NDIG=1) is legal: latency is 2 or 3.

## Structure
- Shared ECC package holds:
  - the state enum (IDLE, SUB, CORR, DONE)
  - the NDIG and index-width derivation function (clog2 of NDIG, minimum 1)
- One sub-module: ecc_digit_addsub. It is a combinational DW-bit add/subtract with carry-in and carry-out, selected by a mode bit (0 = a+b+cin, 1 = a−b−bin). It is shared by SUB and CORR, so the top level holds only the FSM, index counter, operand/result registers and the borrow/carry flop.

## Test plan
Use NBITS=8, DW=4, p=251 unless stated.
- a=200, b=50 -> result=150; done at T+3; CORR never entered.
- a=50, b=200 -> raw 0x6A with borrow, corrected result=101; done at T+5.
- a=b=123 -> result=0; no correction; latency 3.
- a=0, b=250 -> result=1 (correction pass with carry out of the top digit discarded). Then run a=250, b=0 -> result=250.
- start pulsed during SUB with different operands -> ignored; first result unchanged; a start in the cycle after done is accepted normally.
- rst asserted in the second SUB cycle -> done never pulses; busy=0 and result=0 next cycle. A subsequent a=10, b=20 returns 241.
- Randomized regression with NBITS=256, DW=32 and P-256's p checked against a reference model, including latency per the borrow outcome.
